muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl.sv | 175 +++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use 32 shift-add steps; DIV/DIVU use 32 restoring steps.
// Signed operations run on magnitudes, and the signs are fixed up in FIX.
// A result lands in HI/LO 33 edges after the start is accepted.
module muldiv_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    input  logic        rd_req,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wr_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic        div0
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    logic [1:0]  r_state;
    logic [5:0]  r_cnt;
    logic [1:0]  r_op;
    logic [31:0] r_op_a;      // raw dividend, returned in HI on divide by zero
    logic [31:0] r_b_mag;     // multiplier / divisor magnitude
    logic [63:0] r_acc;       // product accumulator, or {remainder, quotient}
    logic [63:0] r_mcand;     // multiplicand, shifted left once per step
    logic        r_neg_q;     // negate the product or quotient
    logic        r_neg_r;     // negate the remainder
    logic        r_b_zero;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;
    logic        r_div0;

    logic        w_accept;
    logic        w_signed_in;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_is_div;
    logic [63:0] w_mul_acc;
    logic        w_div_ge;
    logic [31:0] w_div_trial;
    logic [63:0] w_div_acc;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign busy  = (r_state != ST_IDLE);
    assign stall = busy & (start | rd_req | wr_hi | wr_lo);
    assign hi    = r_hi;
    assign lo    = r_lo;
    assign done  = r_done;
    assign div0  = r_div0;

    assign w_accept    = (r_state == ST_IDLE) && start && !flush;
    assign w_signed_in = ~op[0];
    assign w_mag_a     = (w_signed_in && op_a[31]) ? (32'd0 - op_a) : op_a;
    assign w_mag_b     = (w_signed_in && op_b[31]) ? (32'd0 - op_b) : op_b;
    assign w_is_div    = r_op[1];

    // One shift-add step: add the shifted multiplicand when this multiplier bit is set.
    assign w_mul_acc = r_b_mag[r_cnt[4:0]] ? (r_acc + r_mcand) : r_acc;

    // One restoring step: the partial remainder after the left shift is 33 bits wide
    // (r_acc[63:31]). If the subtraction succeeds, the difference is below the divisor,
    // so its low 32 bits are exact.
    assign w_div_ge    = ({r_acc[63:31]} >= {1'b0, r_b_mag});
    assign w_div_trial = r_acc[62:31] - r_b_mag;
    assign w_div_acc   = w_div_ge ? {w_div_trial, r_acc[30:0], 1'b1}
                                  : {r_acc[62:0], 1'b0};

    // Sign correction applied when the result is committed.
    assign w_prod_fix = r_neg_q ? (64'd0 - r_acc) : r_acc;
    assign w_quo_fix  = r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_rem_fix  = r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

    // Control FSM and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 6'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_CALC;
                        r_cnt   <= 6'd0;
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == 6'd31) begin
                            r_state <= ST_FIX;
                        end
                    end
                end
                ST_FIX:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Operand latch on acceptance, then one arithmetic step per CALC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= 2'd0;
            r_op_a   <= 32'd0;
            r_b_mag  <= 32'd0;
            r_acc    <= 64'd0;
            r_mcand  <= 64'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b_zero <= 1'b0;
        end else if (w_accept) begin
            r_op     <= op;
            r_op_a   <= op_a;
            r_b_mag  <= w_mag_b;
            r_acc    <= op[1] ? {32'd0, w_mag_a} : 64'd0;
            r_mcand  <= {32'd0, w_mag_a};
            r_neg_q  <= w_signed_in & (op_a[31] ^ op_b[31]);
            r_neg_r  <= w_signed_in & op_a[31];
            r_b_zero <= (op_b == 32'd0);
        end else if (r_state == ST_CALC && !flush) begin
            if (w_is_div) begin
                r_acc <= w_div_acc;
            end else begin
                r_acc   <= w_mul_acc;
                r_mcand <= {r_mcand[62:0], 1'b0};
            end
        end
    end

    // Architectural HI/LO: results commit from FIX, MTHI/MTLO only when idle with no start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_done <= 1'b0;
            r_div0 <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_div0 <= 1'b0;
            if (r_state == ST_FIX && !flush) begin
                r_done <= 1'b1;
                if (!w_is_div) begin
                    r_hi <= w_prod_fix[63:32];
                    r_lo <= w_prod_fix[31:0];
                end else if (r_b_zero) begin
                    r_hi   <= r_op_a;
                    r_lo   <= 32'hFFFF_FFFF;
                    r_div0 <= 1'b1;
                end else begin
                    r_hi <= w_rem_fix;
                    r_lo <= w_quo_fix;
                end
            end else if (r_state == ST_IDLE && !start) begin
                if (wr_hi) r_hi <= wr_data;
                if (wr_lo) r_lo <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus randomized operations
// checked against an arithmetic reference model.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        rd_req;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wr_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;
    logic        div0;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_hi = 32'd0;
    logic [31:0] last_lo = 32'd0;

    muldiv_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .op_a    (op_a),
        .op_b    (op_b),
        .flush   (flush),
        .rd_req  (rd_req),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .wr_data (wr_data),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .div0    (div0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: {div0, hi, lo} from plain 64-bit / 32-bit arithmetic.
    function automatic logic [64:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        int                sa;
        int                sb;
        int                q;
        int                r;
        longint            la;
        longint            lb;
        longint unsigned   ua;
        longint unsigned   ub;
        logic [64:0]       res;
        sa = a;
        sb = b;
        la = sa;
        lb = sb;
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = '0;
        if (o == 2'd0) begin
            res = {1'b0, 64'(la * lb)};
        end else if (o == 2'd1) begin
            res = {1'b0, 64'(ua * ub)};
        end else if (b == 32'd0) begin
            res = {1'b1, a, 32'hFFFF_FFFF};
        end else if (o == 2'd2) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                res = {1'b0, 32'd0, 32'h8000_0000};
            end else begin
                q = sa / sb;
                r = sa % sb;
                res = {1'b0, 32'(r), 32'(q)};
            end
        end else begin
            res = {1'b0, a % b, a / b};
        end
        return res;
    endfunction

    function automatic logic [31:0] rnd32();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = $urandom_range(0, 15);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Issue one operation and follow it to its done pulse. With hold set, start stays
    // high so the next call is accepted in the done cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit hold);
        logic [64:0] e;
        int          n;
        bit          got;
        e = ref_model(o, a, b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        op_a  = a;
        op_b  = b;
        @(posedge clk);
        #1;
        chk("busy_accept", busy, 1);
        if (!hold) start = 1'b0;
        n   = 0;
        got = 0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done) begin
                got = 1;
            end else begin
                chk("busy_calc", busy, 1);
                if (n == 10) chk("stall_mid", stall, hold);
                if (n == 16) chk("hilo_stable", {hi, lo}, {last_hi, last_lo});
            end
        end
        chk("latency", n, 33);
        chk("busy_at_done", busy, 0);
        chk("hi", hi, e[63:32]);
        chk("lo", lo, e[31:0]);
        chk("div0", div0, e[64]);
        last_hi = e[63:32];
        last_lo = e[31:0];
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h div0=%0b edges=%0d", o, a, b, hi, lo, div0, n);
        if (!hold) begin
            @(posedge clk);
            #1;
            chk("done_pulse", done, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n_done;
        rst_n   = 1'b1;
        start   = 1'b0;
        op      = 2'd0;
        op_a    = 32'd0;
        op_b    = 32'd0;
        flush   = 1'b0;
        rd_req  = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        wr_data = 32'd0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_busy", busy, 0);
        chk("rst_done", {done, div0, stall}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("reset released");

        // MTLO / MTHI in idle
        @(negedge clk);
        wr_lo = 1'b1; wr_data = 32'h1234_5678;
        @(posedge clk); #1;
        wr_lo = 1'b0;
        chk("wr_lo", {hi, lo}, {32'd0, 32'h1234_5678});
        $display("wr_lo data=12345678 -> lo=%h", lo);
        @(negedge clk);
        wr_hi = 1'b1; wr_data = 32'hCAFE_F00D;
        @(posedge clk); #1;
        wr_hi = 1'b0;
        chk("wr_hi", {hi, lo}, {32'hCAFE_F00D, 32'h1234_5678});
        $display("wr_hi data=cafef00d -> hi=%h", hi);
        last_hi = 32'hCAFE_F00D;
        last_lo = 32'h1234_5678;

        // Write coinciding with start is dropped; write while busy is blocked then flushed
        @(negedge clk);
        start = 1'b1; wr_hi = 1'b1; wr_data = 32'hDEAD_BEEF; op = 2'd1; op_a = 32'd3; op_b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0; wr_hi = 1'b0;
        chk("wr_start_busy", busy, 1);
        chk("wr_start_drop", hi, 32'hCAFE_F00D);
        wr_lo = 1'b1; wr_data = 32'h0BAD_0BAD;
        #1 chk("wr_busy_stall", stall, 1);
        @(posedge clk); #1;
        wr_lo = 1'b0;
        chk("wr_busy_block", lo, 32'h1234_5678);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_hilo", {hi, lo}, {last_hi, last_lo});
        $display("write/start overlap then flush -> hi=%h lo=%h", hi, lo);

        // Flush beats start in idle
        @(negedge clk);
        start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_prio", busy, 0);
        $display("start+flush in idle -> busy=%0b", busy);

        // Directed results
        run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(2'd3, 32'd7, 32'd0, 0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2'd2, 32'h8000_0007, 32'd0, 0);
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 0);

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            run_op(2'($urandom_range(0, 3)), rnd32(), rnd32(), 0);
        end

        // Start held across an operation: second op accepted in the done cycle
        run_op(2'd0, 32'd1000, 32'hFFFF_FFF6, 1);
        run_op(2'd3, 32'd100, 32'd7, 0);

        // rd_req stalls while busy; flush aborts with no result
        @(negedge clk);
        start = 1'b1; op = 2'd1; op_a = 32'd55; op_b = 32'd66;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rd_req = 1'b1;
        #1 chk("rd_stall", stall, 1);
        repeat (5) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_calc_busy", busy, 0);
        chk("flush_calc_stall", stall, 0);
        chk("flush_calc_hilo", {hi, lo}, {last_hi, last_lo});
        rd_req = 1'b0;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        chk("flush_no_done", n_done, 0);
        $display("flush mid-calc -> busy=%0b hi=%h lo=%h dones=%0d", busy, hi, lo, n_done);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        start = 1'b1; op = 2'd2; op_a = 32'd1000; op_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2 rd_req = 1'b1;
        #1 chk("pre_rst_stall", stall, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_hilo", {hi, lo}, 64'd0);
        chk("mid_rst_busy", {busy, stall}, 0);
        rd_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        chk("rst_no_done", n_done, 0);
        chk("rst_idle", busy, 0);
        $display("reset mid-div -> hi=%h lo=%h dones=%0d", hi, lo, n_done);
        last_hi = 32'd0;
        last_lo = 32'd0;

        @(negedge clk);
        wr_lo = 1'b1; wr_data = 32'h1234_5678;
        @(posedge clk); #1;
        wr_lo = 1'b0;
        chk("wr_lo_after_rst", {hi, lo}, {32'd0, 32'h1234_5678});
        $display("wr_lo after reset -> lo=%h", lo);
        last_lo = 32'h1234_5678;
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
